wfg_capture_spi: RTL and testbench
==================================

// Module: wfg_capture_spi
// PURPOSE
//  SPI receiver: the capture-side counterpart of the SPI drive path. Samples an external
//  SPI bus (sclk, cs, sdi), assembles 8/16/24/32-bit words and emits each completed word
//  on an AXI-stream master interface towards the pattern/record logic. Operates in all
//  four SPI modes, MSB/LSB first, with programmable chip-select polarity.
// PARAMETERS
//  AXIS_DATA_WIDTH  32  output stream width; must be 32
// PORTS
//  clk                 in   1   system clock
//  rst_n               in   1   asynchronous reset, active low
//  spi_sclk_i          in   1   SPI clock, asynchronous to clk
//  spi_cs_i            in   1   chip select, asynchronous; active level per cfg_sspol_q_i
//  spi_sdi_i           in   1   serial data in, asynchronous
//  wfg_axis_tvalid_o   out  1   word valid
//  wfg_axis_tready_i   in   1   downstream ready
//  wfg_axis_tdata_o    out  32  received word, right-justified, upper bits zero
//  ctrl_en_q_i         in   1   receiver enable
//  cfg_cpol_q_i        in   1   sclk idle level
//  cfg_cpha_q_i        in   1   0: sample on leading edge; 1: sample on trailing edge
//  cfg_lsbfirst_q_i    in   1   1: first received bit is word bit 0
//  cfg_dff_q_i         in   2   word size = 8*(cfg_dff+1) bits
//  cfg_sspol_q_i       in   1   0: cs active low; 1: cs active high
//  sts_clr_i           in   1   one-cycle pulse, clears sticky status
//  sts_overflow_o      out  1   sticky: completed word dropped (output register occupied)
//  sts_frame_err_o     out  1   sticky: cs released with partial word
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, shift reg/bit counter 0, synchronisers 0.
//  Input sync: sclk/cs/sdi each pass 2 flops; third flop on sclk and cs for edge detect.
//  Sample edge: leading = sclk leaving cpol level; trailing = returning to cpol.
//  Config (cpol, cpha, lsbfirst, dff, sspol) latched on IDLE->RECV; ignored mid-frame.
//  States:
//   IDLE: cs inactive or en=0. -> RECV when en=1 and synced cs becomes active.
//   RECV: on each sample edge store synced sdi; bit k (k=0 first, N=word bits):
//         MSB-first -> word[N-1-k], LSB-first -> word[k]. Counter k wraps 0 after N-1
//         and the word is pushed (multiple back-to-back words per cs frame allowed).
//         cs inactive: k==0 -> IDLE; k!=0 -> discard partial, set sts_frame_err, IDLE.
//         en=0 -> IDLE immediately, partial word discarded, no error flagged.
//  Output: single-entry register. Push with tvalid=0 or (tvalid&&tready) same cycle:
//   load tdata, tvalid=1. Push with tvalid=1 and tready=0: new word dropped, old word
//   held unchanged, sts_overflow set. tvalid drops on tready unless a push coincides.
//   tdata stable while tvalid=1 and tready=0.
//  Latency: tvalid rises on the 3rd clk edge after the final sample edge first appears
//   at spi_sclk_i (2 sync + 1 capture). Each sclk phase must be >= 3 clk cycles.
//  Sticky status: set has priority over sts_clr_i in the same cycle.
//  Async reset mid-frame: everything returns to reset values; receive resumes at next cs assertion.
// TESTING
//  Mode 0, MSB, dff=0, sclk=8clk, send 0xA5 -> one beat tdata=0x000000A5, no status set.
//  Mode 3, LSB, dff=3, send 0x12345678 LSB-first -> tdata=0x12345678.
//  Mode 1, dff=1, cs held, two words 0xBEEF,0x1234 with tready=1 -> two beats in order.
//  tready=0, three 8-bit words 0x11,0x22,0x33 -> tdata held 0x11, overflow=1; clr -> 0.
//  dff=0, cs released after 5 bits -> no beat, frame_err=1; next 0x3C frame -> 0x3C.
//  sspol=1, en dropped after 4 bits, then re-enabled, send 0x81 -> tdata=0x81, no error.

Source files
------------

// File: rtl/wfg_capture_spi.sv
// SPI capture receiver: samples an asynchronous SPI bus in any of the four modes and
// emits each completed 8/16/24/32-bit word on a single-entry AXI-stream master register.
module wfg_capture_spi #(
  parameter int AXIS_DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       spi_sclk_i,
  input  logic                       spi_cs_i,
  input  logic                       spi_sdi_i,
  output logic                       wfg_axis_tvalid_o,
  input  logic                       wfg_axis_tready_i,
  output logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o,
  input  logic                       ctrl_en_q_i,
  input  logic                       cfg_cpol_q_i,
  input  logic                       cfg_cpha_q_i,
  input  logic                       cfg_lsbfirst_q_i,
  input  logic [1:0]                 cfg_dff_q_i,
  input  logic                       cfg_sspol_q_i,
  input  logic                       sts_clr_i,
  output logic                       sts_overflow_o,
  output logic                       sts_frame_err_o
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t state, state_nxt;

  logic sclk_p0, sclk_p1, sclk_p2;
  logic cs_p0, cs_p1, cs_p2;
  logic sdi_p0, sdi_p1;

  logic       cpol_q, cpha_q, lsb_q, sspol_q;
  logic [1:0] dff_q;

  logic [4:0]                 bit_cnt;
  logic [4:0]                 last_idx;
  logic [4:0]                 bit_idx;
  logic [AXIS_DATA_WIDTH-1:0] shift_q;
  logic [AXIS_DATA_WIDTH-1:0] word_p2;

  logic cs_rise, cs_act, sample;
  logic start, take, vld_p2, frame_err_set, overflow_set;

  // Stage p0/p1: two-flop synchronisers; p2 on sclk/cs only, for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      cs_p0   <= 1'b0;
      cs_p1   <= 1'b0;
      cs_p2   <= 1'b0;
      sdi_p0  <= 1'b0;
      sdi_p1  <= 1'b0;
    end else begin
      sclk_p0 <= spi_sclk_i;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      cs_p0   <= spi_cs_i;
      cs_p1   <= cs_p0;
      cs_p2   <= cs_p1;
      sdi_p0  <= spi_sdi_i;
      sdi_p1  <= sdi_p0;
    end
  end

  // Frame start looks at live polarity; mid-frame decisions use the latched copy.
  assign cs_rise  = (cs_p1 == cfg_sspol_q_i) && (cs_p2 != cfg_sspol_q_i);
  assign cs_act   = (cs_p1 == sspol_q);
  assign sample   = (sclk_p1 != sclk_p2) && (sclk_p1 == (cpol_q ^ ~cpha_q));
  assign last_idx = {dff_q, 3'b111};
  assign bit_idx  = lsb_q ? bit_cnt : (last_idx - bit_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    start         = 1'b0;
    take          = 1'b0;
    frame_err_set = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_en_q_i && cs_rise) begin
          state_nxt = RECV;
          start     = 1'b1;
        end
      end
      RECV: begin
        if (!ctrl_en_q_i) begin
          state_nxt = IDLE;
        end else if (!cs_act) begin
          state_nxt     = IDLE;
          frame_err_set = (bit_cnt != 5'd0);
        end else if (sample) begin
          take = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      sspol_q <= 1'b0;
      dff_q   <= 2'd0;
    end else if (start) begin
      cpol_q  <= cfg_cpol_q_i;
      cpha_q  <= cfg_cpha_q_i;
      lsb_q   <= cfg_lsbfirst_q_i;
      sspol_q <= cfg_sspol_q_i;
      dff_q   <= cfg_dff_q_i;
    end
  end

  // Stage p2: capture the synced bit; the final bit is merged straight into the pushed word
  always_comb begin
    word_p2          = shift_q;
    word_p2[bit_idx] = sdi_p1;
  end

  assign vld_p2 = take && (bit_cnt == last_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= 5'd0;
      shift_q <= '0;
    end else if (state == IDLE) begin
      bit_cnt <= 5'd0;
      shift_q <= '0;
    end else if (take) begin
      if (vld_p2) begin
        bit_cnt <= 5'd0;
        shift_q <= '0;
      end else begin
        bit_cnt <= bit_cnt + 5'd1;
        shift_q <= word_p2;
      end
    end
  end

  // Stage p3: single-entry output register; an occupied, stalled register drops new words
  assign overflow_set = vld_p2 && wfg_axis_tvalid_o && !wfg_axis_tready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wfg_axis_tvalid_o <= 1'b0;
      wfg_axis_tdata_o  <= '0;
    end else if (vld_p2 && (!wfg_axis_tvalid_o || wfg_axis_tready_i)) begin
      wfg_axis_tvalid_o <= 1'b1;
      wfg_axis_tdata_o  <= word_p2;
    end else if (wfg_axis_tready_i) begin
      wfg_axis_tvalid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sts_overflow_o  <= 1'b0;
      sts_frame_err_o <= 1'b0;
    end else begin
      sts_overflow_o  <= overflow_set  | (sts_overflow_o  & ~sts_clr_i);
      sts_frame_err_o <= frame_err_set | (sts_frame_err_o & ~sts_clr_i);
    end
  end

endmodule

// File: tb/tb_wfg_capture_spi.sv
// Directed bench for wfg_capture_spi: bit-bangs SPI frames in several modes and checks
// the stream beats and sticky status against hand-computed values.
module tb_wfg_capture_spi;

  localparam int H = 4;  // sclk half period in clk cycles

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk, cs, sdi;
  logic        tvalid, tready;
  logic [31:0] tdata;
  logic        en, cpol, cpha, lsb, sspol, clr;
  logic [1:0]  dff;
  logic        ovf, ferr;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_samp = 0;
  int          beat_cyc = 0;
  logic [31:0] beats[$];

  wfg_capture_spi #(.AXIS_DATA_WIDTH(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .spi_sclk_i        (sclk),
    .spi_cs_i          (cs),
    .spi_sdi_i         (sdi),
    .wfg_axis_tvalid_o (tvalid),
    .wfg_axis_tready_i (tready),
    .wfg_axis_tdata_o  (tdata),
    .ctrl_en_q_i       (en),
    .cfg_cpol_q_i      (cpol),
    .cfg_cpha_q_i      (cpha),
    .cfg_lsbfirst_q_i  (lsb),
    .cfg_dff_q_i       (dff),
    .cfg_sspol_q_i     (sspol),
    .sts_clr_i         (clr),
    .sts_overflow_o    (ovf),
    .sts_frame_err_o   (ferr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tvalid && tready) begin
      beats.push_back(tdata);
      beat_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat(input int i);
    return (beats.size() > i) ? beats[i] : 32'hDEAD_DEAD;
  endfunction

  task automatic cs_on();
    cs = sspol;
    tick(6);
  endtask

  task automatic cs_off();
    tick(H);
    cs = ~sspol;
    tick(10);
  endtask

  // Sends the first nbits of a wbits-wide word in the current mode and bit order.
  task automatic send_word(input logic [31:0] val, input int nbits, input int wbits);
    logic b;
    for (int k = 0; k < nbits; k++) begin
      b = lsb ? val[k] : val[wbits-1-k];
      if (!cpha) begin
        sdi = b;
        tick(H);
        sclk = ~cpol;
        last_samp = cyc;
        tick(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        sdi = b;
        tick(H);
        sclk = cpol;
        last_samp = cyc;
        tick(H);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sclk = 1'b0; cs = 1'b1; sdi = 1'b0;
    tready = 1'b1; en = 1'b1; clr = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; sspol = 1'b0; dff = 2'd0;
    tick(3);
    check("rst_tvalid", {31'd0, tvalid}, 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_overflow", {31'd0, ovf}, 32'd0);
    check("rst_frame_err", {31'd0, ferr}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Mode 0, MSB first, 8 bits
    beats.delete();
    cs_on();
    send_word(32'hA5, 8, 8);
    cs_off();
    check("m0_count", beats.size(), 32'd1);
    check("m0_data", beat(0), 32'h0000_00A5);
    check("m0_latency", beat_cyc - last_samp, 32'd3);
    check("m0_overflow", {31'd0, ovf}, 32'd0);
    check("m0_frame_err", {31'd0, ferr}, 32'd0);

    // Mode 3, LSB first, 32 bits
    cpol = 1'b1; cpha = 1'b1; lsb = 1'b1; dff = 2'd3; sclk = 1'b1;
    tick(4);
    beats.delete();
    cs_on();
    send_word(32'h1234_5678, 32, 32);
    cs_off();
    check("m3_count", beats.size(), 32'd1);
    check("m3_data", beat(0), 32'h1234_5678);

    // Mode 1, MSB first, two 16-bit words in one frame
    cpol = 1'b0; cpha = 1'b1; lsb = 1'b0; dff = 2'd1; sclk = 1'b0;
    tick(4);
    beats.delete();
    cs_on();
    send_word(32'hBEEF, 16, 16);
    send_word(32'h1234, 16, 16);
    cs_off();
    check("m1_count", beats.size(), 32'd2);
    check("m1_word0", beat(0), 32'h0000_BEEF);
    check("m1_word1", beat(1), 32'h0000_1234);
    check("m1_frame_err", {31'd0, ferr}, 32'd0);

    // Stalled output: first word held, later words dropped
    cpha = 1'b0; dff = 2'd0;
    tready = 1'b0;
    tick(4);
    beats.delete();
    cs_on();
    send_word(32'h11, 8, 8);
    send_word(32'h22, 8, 8);
    send_word(32'h33, 8, 8);
    cs_off();
    check("ovf_tvalid", {31'd0, tvalid}, 32'd1);
    check("ovf_tdata", tdata, 32'h0000_0011);
    check("ovf_sticky", {31'd0, ovf}, 32'd1);
    check("ovf_no_beat", beats.size(), 32'd0);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("ovf_cleared", {31'd0, ovf}, 32'd0);
    tready = 1'b1;
    tick(2);
    check("ovf_drain_count", beats.size(), 32'd1);
    check("ovf_drain_data", beat(0), 32'h0000_0011);
    check("ovf_drain_tvalid", {31'd0, tvalid}, 32'd0);

    // cs released after 5 bits, then a good frame
    beats.delete();
    cs_on();
    send_word(32'hB0, 5, 8);
    cs_off();
    check("fe_no_beat", beats.size(), 32'd0);
    check("fe_sticky", {31'd0, ferr}, 32'd1);
    cs_on();
    send_word(32'h3C, 8, 8);
    cs_off();
    check("fe_next_count", beats.size(), 32'd1);
    check("fe_next_data", beat(0), 32'h0000_003C);
    check("fe_still_set", {31'd0, ferr}, 32'd1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("fe_cleared", {31'd0, ferr}, 32'd0);

    // Active-high cs; enable dropped mid-frame discards silently
    sspol = 1'b1;
    tick(4);
    cs = 1'b0;
    tick(6);
    beats.delete();
    cs_on();
    send_word(32'hF0, 4, 8);
    en = 1'b0;
    tick(4);
    en = 1'b1;
    tick(4);
    cs_off();
    check("en_no_beat", beats.size(), 32'd0);
    check("en_no_error", {31'd0, ferr}, 32'd0);
    cs_on();
    send_word(32'h81, 8, 8);
    cs_off();
    check("en_count", beats.size(), 32'd1);
    check("en_data", beat(0), 32'h0000_0081);
    check("en_frame_err", {31'd0, ferr}, 32'd0);

    // Async reset mid-frame, then a fresh frame
    beats.delete();
    cs_on();
    send_word(32'hE0, 3, 8);
    rst_n = 1'b0;
    tick(2);
    check("arst_tvalid", {31'd0, tvalid}, 32'd0);
    check("arst_frame_err", {31'd0, ferr}, 32'd0);
    cs = 1'b0;
    sclk = cpol;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    cs_on();
    send_word(32'h5A, 8, 8);
    cs_off();
    check("arst_count", beats.size(), 32'd1);
    check("arst_data", beat(0), 32'h0000_005A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
